// File: rtl/dispatch_seq_ctrl_pkg.sv
// Shared types for the dispatcher instruction-ROM sequencer.
// State encodings are common with the dispatcher top level.
package dispatch_seq_ctrl_pkg;

  localparam int DEF_LOG_ROM_SIZE  = 5;
  localparam int DEF_LOG_OUT_PORTS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/dispatch_seq_ctrl_stall_popcount.sv
// Counts free (non-stalled) output ports; purely combinational, no backpressure.
module dispatch_seq_ctrl_stall_popcount #(
  parameter int LOG_OUT_PORTS = 3
) (
  input  logic [2**LOG_OUT_PORTS-1:0] i_stall_word,
  output logic [LOG_OUT_PORTS:0]      o_free
);

  always_comb begin
    o_free = '0;
    for (int i = 0; i < 2**LOG_OUT_PORTS; i++) begin
      o_free = o_free + (LOG_OUT_PORTS+1)'(~i_stall_word[i]);
    end
  end

endmodule

// File: rtl/dispatch_seq_ctrl.sv
// Walks a ROM program window issuing up to one word per free output port each cycle.
// First read one cycle after start; all-stalled cycles issue nothing and freeze the pointer.
module dispatch_seq_ctrl
  import dispatch_seq_ctrl_pkg::*;
#(
  parameter int LOG_ROM_SIZE  = DEF_LOG_ROM_SIZE,
  parameter int LOG_OUT_PORTS = DEF_LOG_OUT_PORTS
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [LOG_ROM_SIZE-1:0]     i_base_addr,
  input  logic [LOG_ROM_SIZE:0]       i_length,
  input  logic [2**LOG_OUT_PORTS-1:0] i_stall_word,
  output logic                        o_read,
  output logic [LOG_ROM_SIZE-1:0]     o_addr,
  output logic [LOG_OUT_PORTS:0]      o_n_v_out,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [LOG_ROM_SIZE:0]       o_issued_cnt
);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [LOG_ROM_SIZE-1:0]   r_ptr;
  logic [LOG_ROM_SIZE:0]     r_remaining;
  logic [LOG_ROM_SIZE:0]     r_issued_cnt;
  logic [LOG_OUT_PORTS:0]    w_free;
  logic [LOG_ROM_SIZE:0]     w_free_ext;
  logic [LOG_ROM_SIZE:0]     w_n_ext;
  logic [LOG_OUT_PORTS:0]    w_n;

  dispatch_seq_ctrl_stall_popcount #(
    .LOG_OUT_PORTS (LOG_OUT_PORTS)
  ) u_stall_popcount (
    .i_stall_word (i_stall_word),
    .o_free       (w_free)
  );

  // Words this cycle: free ports, capped by what is left of the program.
  assign w_free_ext = (LOG_ROM_SIZE+1)'(w_free);
  assign w_n_ext    = (w_free_ext < r_remaining) ? w_free_ext : r_remaining;
  assign w_n        = (LOG_OUT_PORTS+1)'(w_n_ext);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) w_next_state = (i_length != '0) ? ST_RUN : ST_FIN;
        ST_RUN:  if (r_remaining == w_n_ext) w_next_state = ST_FIN;
        ST_FIN:  w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_read    = 1'b0;
    o_n_v_out = '0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (r_state)
      ST_RUN: begin
        o_busy = 1'b1;
        if (!i_abort) begin
          o_n_v_out = w_n;
          o_read    = (w_n != '0);
        end
      end
      ST_FIN:  o_done = !i_abort;
      default: ;
    endcase
  end

  // Abort clears the window but keeps the count of what actually went out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr        <= '0;
      r_remaining  <= '0;
      r_issued_cnt <= '0;
    end else if (i_abort) begin
      r_ptr       <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_issued_cnt <= '0;
            if (i_length != '0) begin
              r_ptr       <= i_base_addr;
              r_remaining <= i_length;
            end
          end
        end
        ST_RUN: begin
          r_ptr        <= r_ptr + LOG_ROM_SIZE'(w_n_ext);
          r_remaining  <= r_remaining - w_n_ext;
          r_issued_cnt <= r_issued_cnt + w_n_ext;
        end
        default: ;
      endcase
    end
  end

  assign o_addr       = r_ptr;
  assign o_issued_cnt = r_issued_cnt;

endmodule
